z80_bus_interface: RTL and testbench
====================================

# z80_bus_interface

Front end between the Z80 host bus and Port A of the GPU RAM data mux. It synchronises the asynchronous Z80 strobes into `clk`, decodes a 16 KB memory window plus one bank-select I/O port, and turns each Z80 memory cycle into read or write requests for the mux. It stalls the Z80 with WAIT until read data returns, then drives the captured byte onto the Z80 data bus for the rest of the cycle.

## Interface
Parameters:
- `WINDOW_TAG`, 2'b10: value of `z80_addr[15:14]` that selects GPU RAM (0x8000–0xBFFF).
- `IO_BANK_PORT`, 8'hF0: `z80_addr[7:0]` of the bank-select I/O port.
- `TIMEOUT`, 15: number of clocks in RD_WAIT without `gpu_rd_rdy_a` before the read is abandoned.

Ports:
- `clk`  in  1  system clock. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `z80_addr`  in  16  Z80 address bus (asynchronous).
- `z80_data_in`  in  8  Z80 data bus, input side.
- `z80_mreq_n`, `z80_iorq_n`, `z80_rd_n`, `z80_wr_n`, `z80_m1_n`  in  1 each  Z80 strobes (asynchronous, active-low).
- `z80_data_out`  out  8  byte driven to the Z80 during reads.
- `z80_data_oe`  out  1  high while the block drives the Z80 data bus.
- `z80_wait_n`  out  1  Z80 WAIT. Low stalls the CPU.
- `rd_req_a`  out  1  read request to mux Port A.
- `wr_ena_a`  out  1  write request to mux Port A.
- `address_a`  out  20  `{bank[5:0], z80_addr[13:0]}`.
- `data_in_a`  out  8  write data to the mux.
- `gpu_rd_rdy_a`  in  1  one-clock pulse from the mux: `data_out_a` is valid.
- `data_out_a`  in  8  read data from the mux.
- `bank`  out  6  current bank register, exported for debug.

## Operation
- **Strobe synchronisation:** each strobe passes through 2 flops. Decoding uses only the synchronised versions. The address and data inputs are sampled on the clock where a synchronised strobe first asserts; by then they are stable.
- **Decodes (all require a synchronised strobe to be active):**
  - MEMRD: `mreq`, `rd`, window hit.
  - MEMWR: `mreq`, `wr`, window hit.
  - IORD / IOWR: `iorq`, `m1_n` high, `addr[7:0]==IO_BANK_PORT`.
  - An `iorq` cycle with `m1` low is an interrupt acknowledge and is ignored.
- **States:** IDLE, WR_ISSUE, RD_WAIT, RD_HOLD, END_WAIT.
- **IDLE:**
  - On MEMWR: latch `address_a` and `data_in_a`, assert `wr_ena_a`, go to WR_ISSUE.
  - On MEMRD: latch `address_a`, assert `rd_req_a`, drive `z80_wait_n` low, go to RD_WAIT.
  - On IOWR: `bank <= z80_data_in[5:0]`, go to END_WAIT.
  - On IORD: `z80_data_out <= {2'b00, bank}`, `z80_data_oe <= 1`, go to RD_HOLD.
- **WR_ISSUE:**
  - `wr_ena_a` stays high for exactly 2 clocks, because the mux can ignore Port A for one clock after a Port B access. Writing the same byte twice is harmless.
  - Then deassert `wr_ena_a` and go to END_WAIT.
- **RD_WAIT:**
  - `rd_req_a` stays high until `gpu_rd_rdy_a`. Repeated reads are harmless.
  - On the first `gpu_rd_rdy_a`: latch `data_out_a` into `z80_data_out`, drop `rd_req_a`, raise `z80_wait_n` and `z80_data_oe`, go to RD_HOLD.
  - After `TIMEOUT` clocks with no ready: the same exit, but with data 8'hFF.
- **RD_HOLD:** keep driving until the synchronised `rd` or strobe deasserts, then set `z80_data_oe <= 0` and go to IDLE.
- **END_WAIT:** wait for the synchronised strobe to deassert, then go to IDLE. A cycle is never issued twice for one Z80 access.
- **Precedence and exclusivity:**
  - Only IDLE decodes new cycles.
  - MEMWR has priority over MEMRD if both appear (a glitch case).
  - `rd_req_a` and `wr_ena_a` are never high together.
- **Reset:** takes effect on any clock, including mid-cycle. All outputs go to reset values and the state goes to IDLE. A Z80 access that was in progress completes as a no-op through END_WAIT: strobes still asserted after reset are ignored until they deassert.

## Timing
- **Reset values:**
  - `z80_wait_n`=1; `z80_data_oe`=0.
  - `rd_req_a`=0; `wr_ena_a`=0.
  - `z80_data_out`=0; `address_a`=0; `data_in_a`=0.
  - `bank`=0.
- **Strobe to request:** with the strobe falling before edge N, the synchronised strobe is seen at N+2 and `rd_req_a`/`wr_ena_a` are high from edge N+3.
- **Read latency:** against a mux with a 2-cycle delay, `gpu_rd_rdy_a` arrives 3 clocks after the first accepted request. `z80_data_oe` and `z80_wait_n`=1 are registered on the following edge.
- **WAIT timing:** `z80_wait_n` goes low on the same edge as `rd_req_a`. The host clock must be slow enough that this happens before the Z80 samples WAIT in T2; this is a system requirement, not checked here.
- **End of cycle:** `z80_data_oe` falls 3 clocks after `rd_n` rises (2 synchroniser flops + 1 register).

## Test plan
- **Memory write:** MEMWR to 0x8123 with data 0x5A, bank=0x03 → `wr_ena_a` high 2 clocks, `address_a`=0x0C123, `data_in_a`=0x5A, no second write while the strobe is held.
- **Memory read:** MEMRD to 0xBFFF, bank=0x3F; mux model returns 0xA7 three clocks later → `address_a`=0xFFFFF, `z80_wait_n` low, then high with `z80_data_out`=0xA7 and `z80_data_oe`=1 until `rd_n` rises plus 3 clocks.
- **Port A blocked:** a Port B access in flight blocks the first request clock → read still completes with correct data; write still lands exactly once per 2-clock pulse.
- **Bank port and interrupt acknowledge:**
  - IOWR 0xF0 with data 0xE9 → `bank`=0x29.
  - IORD 0xF0 → `z80_data_out`=0x29.
  - `iorq` with `m1` low → no response.
- **Timeout:** `gpu_rd_rdy_a` never pulses → after 15 clocks `z80_wait_n`=1 and `z80_data_out`=0xFF.
- **Out of window and reset:** access to 0x7FFF → no mux request. Reset asserted in RD_WAIT → all outputs at reset values next edge, no request until the strobe deasserts and reasserts.

Source files
------------

// File: rtl/z80_bus_interface.sv
// Z80 host bus front end for GPU RAM Port A. It synchronises the Z80 strobes and decodes the
// 16 KB window and the bank port. It then issues mux requests and holds WAIT until read data returns.
module z80_bus_interface #(
  parameter logic [1:0] WINDOW_TAG   = 2'b10,
  parameter logic [7:0] IO_BANK_PORT = 8'hF0,
  parameter int         TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  input  logic        z80_mreq_n,
  input  logic        z80_iorq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_m1_n,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  output logic        z80_wait_n,
  output logic        rd_req_a,
  output logic        wr_ena_a,
  output logic [19:0] address_a,
  output logic [7:0]  data_in_a,
  input  logic        gpu_rd_rdy_a,
  input  logic [7:0]  data_out_a,
  output logic [5:0]  bank
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_RD_WAIT,
    S_RD_HOLD,
    S_END_WAIT
  } state_t;

  // Strobe vector bit order: mreq, iorq, rd, wr, m1.
  logic [4:0]  strobe_n;
  logic [4:0]  sync1_q;
  logic [4:0]  sync2_q;
  logic [4:0]  act_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;

  assign strobe_n = {z80_m1_n, z80_wr_n, z80_rd_n, z80_iorq_n, z80_mreq_n};

  // The synchroniser is left out of reset on purpose. A strobe that is held through reset
  // must still read as held, so that the access is not mistaken for a new cycle.
  always_ff @(posedge clk) begin
    sync1_q <= strobe_n;
    sync2_q <= sync1_q;
    act_q   <= ~sync2_q;
    addr_q  <= z80_addr;
    wdata_q <= z80_data_in;
  end

  logic mreq_s, iorq_s, rd_s, wr_s, m1_s;
  logic win_hit, port_hit, any_access;
  logic memwr, memrd, iowr, iord;

  assign mreq_s     = act_q[0];
  assign iorq_s     = act_q[1];
  assign rd_s       = act_q[2];
  assign wr_s       = act_q[3];
  assign m1_s       = act_q[4];
  assign win_hit    = (addr_q[15:14] == WINDOW_TAG);
  assign port_hit   = (addr_q[7:0] == IO_BANK_PORT);
  assign any_access = mreq_s | iorq_s;

  assign memwr = mreq_s & wr_s & win_hit;
  assign memrd = mreq_s & rd_s & win_hit;
  assign iowr  = iorq_s & ~m1_s & wr_s & port_hit;
  assign iord  = iorq_s & ~m1_s & rd_s & port_hit;

  state_t        state_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          wr_second_q;
  logic          block_q;
  logic [7:0]    data_out_q;
  logic          data_oe_q;
  logic          wait_n_q;
  logic          rd_req_q;
  logic          wr_ena_q;
  logic [19:0]   address_q;
  logic [7:0]    data_in_q;
  logic [5:0]    bank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmo_cnt_q   <= '0;
      wr_second_q <= 1'b0;
      block_q     <= 1'b1;
      data_out_q  <= 8'h00;
      data_oe_q   <= 1'b0;
      wait_n_q    <= 1'b1;
      rd_req_q    <= 1'b0;
      wr_ena_q    <= 1'b0;
      address_q   <= '0;
      data_in_q   <= 8'h00;
      bank_q      <= 6'h00;
    end else begin
      // After reset, any access still in progress must finish before a new one is decoded.
      if (!any_access) begin
        block_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (!block_q) begin
            if (memwr) begin
              address_q   <= {bank_q, addr_q[13:0]};
              data_in_q   <= wdata_q;
              wr_ena_q    <= 1'b1;
              wr_second_q <= 1'b0;
              state_q     <= S_WR_ISSUE;
            end else if (memrd) begin
              address_q <= {bank_q, addr_q[13:0]};
              rd_req_q  <= 1'b1;
              wait_n_q  <= 1'b0;
              tmo_cnt_q <= '0;
              state_q   <= S_RD_WAIT;
            end else if (iowr) begin
              bank_q  <= wdata_q[5:0];
              state_q <= S_END_WAIT;
            end else if (iord) begin
              data_out_q <= {2'b00, bank_q};
              data_oe_q  <= 1'b1;
              state_q    <= S_RD_HOLD;
            end
          end
        end
        S_WR_ISSUE: begin
          // The write is held for two clocks so that it survives one clock blocked by Port B.
          if (!wr_second_q) begin
            wr_second_q <= 1'b1;
          end else begin
            wr_second_q <= 1'b0;
            wr_ena_q    <= 1'b0;
            state_q     <= S_END_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (gpu_rd_rdy_a) begin
            data_out_q <= data_out_a;
            rd_req_q   <= 1'b0;
            wait_n_q   <= 1'b1;
            data_oe_q  <= 1'b1;
            state_q    <= S_RD_HOLD;
          end else if (tmo_cnt_q == TMO_LAST) begin
            data_out_q <= 8'hFF;
            rd_req_q   <= 1'b0;
            wait_n_q   <= 1'b1;
            data_oe_q  <= 1'b1;
            state_q    <= S_RD_HOLD;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_RD_HOLD: begin
          if (!rd_s || !any_access) begin
            data_oe_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_END_WAIT: begin
          if (!any_access) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign z80_data_out = data_out_q;
  assign z80_data_oe  = data_oe_q;
  assign z80_wait_n   = wait_n_q;
  assign rd_req_a     = rd_req_q;
  assign wr_ena_a     = wr_ena_q;
  assign address_a    = address_q;
  assign data_in_a    = data_in_q;
  assign bank         = bank_q;

endmodule

// File: tb/tb_z80_bus_interface.sv
// Testbench for z80_bus_interface. It drives directed and random Z80 cycles against a Port A mux model
// and checks them with a reference model of the bank register and GPU memory contents.
module tb_z80_bus_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] z80_addr;
  logic [7:0]  z80_data_in;
  logic        z80_mreq_n, z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n;
  logic [7:0]  z80_data_out;
  logic        z80_data_oe, z80_wait_n;
  logic        rd_req_a, wr_ena_a;
  logic [19:0] address_a;
  logic [7:0]  data_in_a;
  logic        gpu_rd_rdy_a;
  logic [7:0]  data_out_a;
  logic [5:0]  bank;

  z80_bus_interface dut (
    .clk(clk), .reset(reset),
    .z80_addr(z80_addr), .z80_data_in(z80_data_in),
    .z80_mreq_n(z80_mreq_n), .z80_iorq_n(z80_iorq_n), .z80_rd_n(z80_rd_n),
    .z80_wr_n(z80_wr_n), .z80_m1_n(z80_m1_n),
    .z80_data_out(z80_data_out), .z80_data_oe(z80_data_oe), .z80_wait_n(z80_wait_n),
    .rd_req_a(rd_req_a), .wr_ena_a(wr_ena_a), .address_a(address_a), .data_in_a(data_in_a),
    .gpu_rd_rdy_a(gpu_rd_rdy_a), .data_out_a(data_out_a), .bank(bank)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Mux model state
  bit         mux_block = 1'b0;
  int         mux_delay = 3;
  logic [7:0] mux_mem [int];
  int         wr_clocks = 0;
  int         wr_lands  = 0;

  // Reference model
  logic [5:0] ref_bank;
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_byte(input int a);
    return a[7:0] ^ a[19:12] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mux_rd(input int a);
    if (mux_mem.exists(a)) return mux_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Port A mux: two-cycle read delay. When blocked, it also ignores the first clock of each request.
  initial begin
    int  age;
    bit  prev_wr;
    age = 0;
    prev_wr = 1'b0;
    gpu_rd_rdy_a = 1'b0;
    data_out_a = 8'h00;
    forever begin
      @(negedge clk);
      gpu_rd_rdy_a = 1'b0;
      n_assert++;
      assert (!(rd_req_a === 1'b1 && wr_ena_a === 1'b1)) else begin
        n_fail++;
        $error("FAIL req_exclusive: observed rd_req_a=%b wr_ena_a=%b expected not both 1", rd_req_a, wr_ena_a);
      end
      if (wr_ena_a) begin
        wr_clocks++;
        if (!(mux_block && !prev_wr)) begin
          mux_mem[int'(address_a)] = data_in_a;
          wr_lands++;
        end
      end
      prev_wr = wr_ena_a;
      if (rd_req_a) begin
        if (age == mux_delay - 1 + (mux_block ? 1 : 0)) begin
          gpu_rd_rdy_a = 1'b1;
          data_out_a = mux_rd(int'(address_a));
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed time limit reached expected end of test");
    $fatal(1, "simulation time limit");
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    int first_c, wc0, wl0, exp_addr;
    bit in_win;
    in_win   = (a[15:14] == 2'b10);
    exp_addr = int'({ref_bank, a[13:0]});
    wc0 = wr_clocks;
    wl0 = wr_lands;
    first_c = -1;
    z80_addr = a; z80_data_in = d; z80_mreq_n = 1'b0; z80_wr_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_ena_a && first_c < 0) begin
        first_c = c;
        check("wr_addr", address_a, exp_addr);
        check("wr_data", data_in_a, d);
      end
    end
    z80_mreq_n = 1'b1; z80_wr_n = 1'b1;
    idle_cycles(4);
    if (in_win) begin
      ref_mem[exp_addr] = d;
      check("wr_first_clock", first_c, 3);
      check("wr_clocks", wr_clocks - wc0, 2);
      check("wr_lands", wr_lands - wl0, mux_block ? 1 : 2);
      check("wr_mem", mux_rd(exp_addr), d);
    end else begin
      check("oow_wr_clocks", wr_clocks - wc0, 0);
    end
    $display("MEMWR addr=%h data=%h bank=%h block=%0d", a, d, ref_bank, mux_block);
  endtask

  task automatic mem_read(input logic [15:0] a, input bit timeout);
    int c_req, c_wait, c_done, c_oe, exp_addr;
    bit in_win, oe_seen;
    logic [7:0] exp_data;
    in_win   = (a[15:14] == 2'b10);
    exp_addr = int'({ref_bank, a[13:0]});
    exp_data = timeout ? 8'hFF : ref_rd(exp_addr);
    mux_delay = timeout ? 1000 : 3;
    c_req = -1; c_wait = -1; c_done = -1; c_oe = -1; oe_seen = 1'b0;
    z80_addr = a; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (z80_data_oe) oe_seen = 1'b1;
      if (rd_req_a && c_req < 0) begin
        c_req = c;
        check("rd_addr", address_a, exp_addr);
      end
      if (!z80_wait_n && c_wait < 0) c_wait = c;
      if (c_req >= 0 && z80_wait_n && c_done < 0) begin
        c_done = c;
        check("rd_data", z80_data_out, exp_data);
        check("rd_oe", z80_data_oe, 1'b1);
      end
    end
    if (in_win) begin
      check("rd_oe_held", z80_data_oe, 1'b1);
      check("rd_wait_released", z80_wait_n, 1'b1);
    end
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (!z80_data_oe && c_oe < 0) c_oe = c;
    end
    if (in_win) begin
      check("rd_req_clock", c_req, 3);
      check("rd_wait_clock", c_wait, c_req);
      check("rd_latency", c_done - c_req, timeout ? 15 : (mux_block ? 4 : 3));
      check("rd_oe_fall_clock", c_oe, 3);
    end else begin
      check("oow_rd_req", c_req, -1);
      check("oow_rd_wait", c_wait, -1);
      check("oow_rd_oe", oe_seen, 1'b0);
    end
    mux_delay = 3;
    idle_cycles(2);
    $display("MEMRD addr=%h expect=%h got=%h bank=%h block=%0d timeout=%0d", a, exp_data, z80_data_out, ref_bank, mux_block, timeout);
  endtask

  task automatic io_write(input logic [7:0] d);
    int wc0;
    wc0 = wr_clocks;
    z80_addr = {8'($urandom), 8'hF0}; z80_data_in = d;
    z80_m1_n = 1'b1; z80_iorq_n = 1'b0; z80_wr_n = 1'b0;
    idle_cycles(6);
    z80_iorq_n = 1'b1; z80_wr_n = 1'b1;
    idle_cycles(4);
    ref_bank = d[5:0];
    check("iowr_bank", bank, ref_bank);
    check("iowr_no_mux_write", wr_clocks - wc0, 0);
    $display("IOWR data=%h bank=%h", d, bank);
  endtask

  task automatic io_read();
    z80_addr = {8'($urandom), 8'hF0};
    z80_m1_n = 1'b1; z80_iorq_n = 1'b0; z80_rd_n = 1'b0;
    idle_cycles(6);
    check("iord_oe", z80_data_oe, 1'b1);
    check("iord_data", z80_data_out, {2'b00, ref_bank});
    check("iord_wait", z80_wait_n, 1'b1);
    z80_iorq_n = 1'b1; z80_rd_n = 1'b1;
    idle_cycles(5);
    check("iord_oe_release", z80_data_oe, 1'b0);
    $display("IORD data=%h", z80_data_out);
  endtask

  task automatic int_ack(input bit use_wr);
    bit oe_seen, req_seen;
    oe_seen = 1'b0; req_seen = 1'b0;
    z80_addr = {8'($urandom), 8'hF0}; z80_data_in = 8'($urandom);
    z80_m1_n = 1'b0; z80_iorq_n = 1'b0;
    if (use_wr) z80_wr_n = 1'b0; else z80_rd_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (z80_data_oe) oe_seen = 1'b1;
      if (rd_req_a || wr_ena_a || !z80_wait_n) req_seen = 1'b1;
    end
    z80_m1_n = 1'b1; z80_iorq_n = 1'b1; z80_wr_n = 1'b1; z80_rd_n = 1'b1;
    idle_cycles(4);
    check("intack_oe", oe_seen, 1'b0);
    check("intack_req", req_seen, 1'b0);
    check("intack_bank", bank, ref_bank);
    $display("INTACK use_wr=%0d bank=%h", use_wr, bank);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wait_n"}, z80_wait_n, 1'b1);
    check({tag, "_oe"}, z80_data_oe, 1'b0);
    check({tag, "_rd_req"}, rd_req_a, 1'b0);
    check({tag, "_wr_ena"}, wr_ena_a, 1'b0);
    check({tag, "_data_out"}, z80_data_out, 8'h00);
    check({tag, "_address"}, address_a, 20'h0);
    check({tag, "_data_in"}, data_in_a, 8'h00);
    check({tag, "_bank"}, bank, 6'h00);
  endtask

  initial begin
    int op;
    bit req_seen;
    logic [15:0] a;
    reset = 1'b1;
    z80_addr = 16'h0000; z80_data_in = 8'h00;
    z80_mreq_n = 1'b1; z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_m1_n = 1'b1;
    ref_bank = 6'h00;
    idle_cycles(5);
    check_reset_values("reset");
    reset = 1'b0;
    idle_cycles(4);
    check_reset_values("post_reset");
    $display("RESET released");

    // Write to 0x8123 through bank 3, then read 0xBFFF through bank 0x3F.
    io_write(8'h03);
    mem_write(16'h8123, 8'h5A);
    check("plan_wr_mem", mux_rd(20'h0C123), 8'h5A);
    io_write(8'h3F);
    mux_mem[20'hFFFFF] = 8'hA7;
    ref_mem[20'hFFFFF] = 8'hA7;
    mem_read(16'hBFFF, 1'b0);
    check("plan_rd_data", z80_data_out, 8'hA7);

    // Port A blocked by a Port B access
    mux_block = 1'b1;
    mem_read(16'hBFFF, 1'b0);
    mem_write(16'h8200, 8'h6C);
    mux_block = 1'b0;

    // Bank port and interrupt acknowledge
    io_write(8'hE9);
    check("plan_bank", bank, 6'h29);
    io_read();
    check("plan_iord", z80_data_out, 8'h29);
    int_ack(1'b0);
    int_ack(1'b1);

    // Timeout, then out-of-window accesses
    mem_read(16'h9000, 1'b1);
    mem_read(16'h7FFF, 1'b0);
    mem_write(16'h7FFF, 8'h11);

    // Reset during RD_WAIT
    mux_delay = 1000;
    z80_addr = 16'hA010; z80_mreq_n = 1'b0; z80_rd_n = 1'b0;
    for (int c = 0; c < 10 && !rd_req_a; c++) @(negedge clk);
    check("rst_mid_in_rd_wait", rd_req_a, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst_mid");
    reset = 1'b0;
    ref_bank = 6'h00;
    req_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_req_a || !z80_wait_n || z80_data_oe) req_seen = 1'b1;
    end
    check("rst_mid_no_request", req_seen, 1'b0);
    z80_mreq_n = 1'b1; z80_rd_n = 1'b1;
    idle_cycles(4);
    mux_delay = 3;
    $display("RESET mid-read done");
    mem_read(16'hA010, 1'b0);

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 6));
      mux_block = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) a = {2'b10, 12'h000, 2'($urandom)};
      else a = {2'b10, 14'($urandom)};
      case (op)
        0, 1: mem_write(a, 8'($urandom));
        2, 3: mem_read(a, 1'b0);
        4: io_write(8'($urandom));
        5: io_read();
        default: begin
          a[15:14] = 2'($urandom_range(0, 1)) ^ {1'b0, 1'($urandom)};
          if ($urandom_range(0, 1) == 0) mem_read(a, 1'b0); else mem_write(a, 8'($urandom));
        end
      endcase
    end
    mux_block = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
